// File: rtl/spi_scheduler.sv
// spi_scheduler: round-robin sequencer that shares one SPI master between
// up to CHANNELS requesters. Each requester owns the CS index equal to its
// channel number. The winner's datagram is handed to the master, the
// scheduler waits out the transfer and returns the received datagram with a
// one-cycle done pulse (plus an error flag if the master never started).
module spi_scheduler #(
  parameter int CHANNELS  = 12,
  parameter int SIZE      = 40,
  parameter int SEL_WIDTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic [CHANNELS-1:0]      req_in,
  input  logic [CHANNELS*SIZE-1:0] req_data_in,
  output logic [CHANNELS-1:0]      grant_out,
  output logic [CHANNELS-1:0]      done_out,
  output logic                     err_out,
  output logic [SIZE-1:0]          resp_data_out,
  output logic                     busy_out,
  output logic [SIZE-1:0]          spi_data_out,
  output logic [SEL_WIDTH-1:0]     spi_cs_select_out,
  output logic                     spi_send_enable_out,
  input  logic                     spi_ready_in,
  input  logic [SIZE-1:0]          spi_data_in
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    DONE
  } state_e;

  // The start phase gives up after TIMEOUT cycles, so the counter compares
  // against the last legal count value rather than TIMEOUT itself.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   last_q, last_d;
  logic [CHANNELS-1:0]    grant_q, grant_d;
  logic [CHANNELS-1:0]    done_q, done_d;
  logic                   err_q, err_d;
  logic [SIZE-1:0]        resp_q, resp_d;
  logic [SIZE-1:0]        data_q, data_d;
  logic [SEL_WIDTH-1:0]   cs_q, cs_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic [7:0]             cnt_q, cnt_d;

  logic                   found;
  logic [SEL_WIDTH-1:0]   winner;

  // Round-robin search: scan from the channel after the last winner,
  // wrapping around, and take the first active request.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = int'(last_q) + k;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!found && req_in[idx]) begin
        found  = 1'b1;
        winner = SEL_WIDTH'(idx);
      end
    end
  end

  // Next-state and next-output logic; every output is computed here one
  // cycle ahead so that all ports come straight from flops.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    resp_d  = resp_q;
    data_d  = data_q;
    cs_d    = cs_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = START;
          grant_d = CHANNELS'(1) << winner;
          data_d  = req_data_in[winner*SIZE +: SIZE];
          cs_d    = winner;
          last_d  = winner;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      START: begin
        if (!spi_ready_in) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = DONE;
          grant_d = '0;
          done_d  = grant_q;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          en_d  = 1'b1;
        end
      end

      WAIT_DONE: begin
        if (spi_ready_in) begin
          state_d = DONE;
          resp_d  = spi_data_in;
          grant_d = '0;
          done_d  = grant_q;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves channel 0 first in line.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      last_q  <= SEL_WIDTH'(CHANNELS - 1);
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      resp_q  <= '0;
      data_q  <= '0;
      cs_q    <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_out           = grant_q;
  assign done_out            = done_q;
  assign err_out             = err_q;
  assign resp_data_out       = resp_q;
  assign busy_out            = busy_q;
  assign spi_data_out        = data_q;
  assign spi_cs_select_out   = cs_q;
  assign spi_send_enable_out = en_q;

endmodule

// File: tb/tb_spi_scheduler.sv
// Directed bench for spi_scheduler with a small behavioural SPI master.
module tb_spi_scheduler;

  localparam int CH = 12;
  localparam int SZ = 40;
  localparam int SW = 4;

  logic                clk_in = 1'b0;
  logic                reset_n_in;
  logic [CH-1:0]       req_in;
  logic [CH*SZ-1:0]    req_data_in;
  logic [CH-1:0]       grant_out;
  logic [CH-1:0]       done_out;
  logic                err_out;
  logic [SZ-1:0]       resp_data_out;
  logic                busy_out;
  logic [SZ-1:0]       spi_data_out;
  logic [SW-1:0]       spi_cs_select_out;
  logic                spi_send_enable_out;
  logic                spi_ready_in;
  logic [SZ-1:0]       spi_data_in;

  int total = 0;
  int bad   = 0;

  bit          masterOn;
  int          dropDelay;
  int          xferLen;
  logic [SZ-1:0] masterResp;

  spi_scheduler #(
    .CHANNELS (CH),
    .SIZE     (SZ),
    .SEL_WIDTH(SW),
    .TIMEOUT  (8)
  ) dut (
    .clk_in             (clk_in),
    .reset_n_in         (reset_n_in),
    .req_in             (req_in),
    .req_data_in        (req_data_in),
    .grant_out          (grant_out),
    .done_out           (done_out),
    .err_out            (err_out),
    .resp_data_out      (resp_data_out),
    .busy_out           (busy_out),
    .spi_data_out       (spi_data_out),
    .spi_cs_select_out  (spi_cs_select_out),
    .spi_send_enable_out(spi_send_enable_out),
    .spi_ready_in       (spi_ready_in),
    .spi_data_in        (spi_data_in)
  );

  // 25 MHz system clock.
  always #20 clk_in = ~clk_in;

  // Behavioural master: on send-enable, drop ready after dropDelay cycles,
  // hold it low for xferLen cycles, then present masterResp with ready high.
  initial begin
    spi_ready_in = 1'b1;
    spi_data_in  = '0;
    forever begin
      @(negedge clk_in);
      if (masterOn && spi_send_enable_out) begin
        repeat (dropDelay - 1) @(negedge clk_in);
        spi_ready_in = 1'b0;
        repeat (xferLen) @(negedge clk_in);
        spi_data_in  = masterResp;
        spi_ready_in = 1'b1;
      end
    end
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [SZ-1:0] sliceData(input int i);
    if (i == 2) return 40'h12_3456_789A;
    return {8'hD0 + 8'(i), 32'h1111_1111 * 32'(i)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] req);
    req_in = req;
  endtask

  task automatic waitGrant(output int cycles);
    cycles = 0;
    while (grant_out == '0 && cycles < 200) begin
      @(negedge clk_in);
      cycles++;
    end
    checkOutput("grantSeen", 64'(grant_out != '0), 64'd1);
  endtask

  task automatic waitDone();
    int cycles;
    cycles = 0;
    while (done_out == '0 && cycles < 300) begin
      @(negedge clk_in);
      cycles++;
    end
    checkOutput("doneSeen", 64'(done_out != '0), 64'd1);
  endtask

  initial begin
    int cyc;
    int enCount;
    int k;
    bit sawGrant;
    logic [SZ-1:0] expResp;

    reset_n_in = 1'b0;
    applyStimulus('0);
    masterOn   = 1'b1;
    dropDelay  = 2;
    xferLen    = 45;
    masterResp = 40'hAB_CDEF_0123;
    for (int i = 0; i < CH; i++) begin
      req_data_in[i*SZ +: SZ] = sliceData(i);
    end

    // Reset state
    repeat (2) @(negedge clk_in);
    checkOutput("rstGrant", 64'(grant_out), 64'd0);
    checkOutput("rstDone", 64'(done_out), 64'd0);
    checkOutput("rstErr", 64'(err_out), 64'd0);
    checkOutput("rstBusy", 64'(busy_out), 64'd0);
    checkOutput("rstEn", 64'(spi_send_enable_out), 64'd0);
    checkOutput("rstData", 64'(spi_data_out), 64'd0);
    checkOutput("rstCs", 64'(spi_cs_select_out), 64'd0);
    checkOutput("rstResp", 64'(resp_data_out), 64'd0);
    reset_n_in = 1'b1;
    @(negedge clk_in);

    // Single request on channel 2
    applyStimulus(12'h004);
    waitGrant(cyc);
    checkOutput("singleLatency", 64'(cyc), 64'd1);
    checkOutput("singleGrant", 64'(grant_out), 64'h004);
    checkOutput("singleCs", 64'(spi_cs_select_out), 64'd2);
    checkOutput("singleData", 64'(spi_data_out), 64'h12_3456_789A);
    checkOutput("singleEn", 64'(spi_send_enable_out), 64'd1);
    checkOutput("singleBusy", 64'(busy_out), 64'd1);
    waitDone();
    checkOutput("singleDone", 64'(done_out), 64'h004);
    checkOutput("singleErr", 64'(err_out), 64'd0);
    checkOutput("singleResp", 64'(resp_data_out), 64'hAB_CDEF_0123);
    checkOutput("singleGrantOff", 64'(grant_out), 64'd0);
    applyStimulus('0);
    @(negedge clk_in);
    checkOutput("singleDonePulse", 64'(done_out), 64'd0);
    checkOutput("singleIdleBusy", 64'(busy_out), 64'd0);
    checkOutput("singleDataHold", 64'(spi_data_out), 64'h12_3456_789A);
    expResp = 40'hAB_CDEF_0123;

    // Round-robin sweep with every channel requesting
    reset_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_n_in = 1'b1;
    dropDelay  = 1;
    xferLen    = 3;
    masterResp = 40'h55_AA55_AA55;
    applyStimulus(12'hFFF);
    for (int n = 0; n < 13; n++) begin
      waitGrant(cyc);
      checkOutput($sformatf("rrGrant%0d", n), 64'(grant_out), 64'(12'h001 << (n % 12)));
      checkOutput($sformatf("rrCs%0d", n), 64'(spi_cs_select_out), 64'(n % 12));
      if (n == 12) applyStimulus('0);
      waitDone();
      checkOutput($sformatf("rrDone%0d", n), 64'(done_out), 64'(12'h001 << (n % 12)));
    end
    repeat (4) @(negedge clk_in);
    checkOutput("rrIdle", 64'(grant_out), 64'd0);
    expResp = 40'h55_AA55_AA55;
    checkOutput("rrResp", 64'(resp_data_out), 64'(expResp));

    // Priority skip: last = 5, then channels 0 and 5 both request
    applyStimulus(12'h020);
    waitGrant(cyc);
    checkOutput("skipSetup", 64'(grant_out), 64'h020);
    checkOutput("skipSetupData", 64'(spi_data_out), 64'(sliceData(5)));
    waitDone();
    applyStimulus(12'h021);
    waitGrant(cyc);
    checkOutput("skipFirst", 64'(grant_out), 64'h001);
    waitDone();
    applyStimulus(12'h020);
    waitGrant(cyc);
    checkOutput("skipSecond", 64'(grant_out), 64'h020);
    waitDone();
    applyStimulus('0);

    // Timeout with ready stuck high
    @(negedge clk_in);
    masterOn = 1'b0;
    applyStimulus(12'h008);
    waitGrant(cyc);
    enCount = 0;
    k = 0;
    while (done_out == '0 && k < 100) begin
      if (spi_send_enable_out) enCount++;
      @(negedge clk_in);
      k++;
    end
    checkOutput("tmoEnCycles", 64'(enCount), 64'd8);
    checkOutput("tmoDone", 64'(done_out), 64'h008);
    checkOutput("tmoErr", 64'(err_out), 64'd1);
    checkOutput("tmoResp", 64'(resp_data_out), 64'(expResp));
    applyStimulus('0);
    @(negedge clk_in);
    checkOutput("tmoErrPulse", 64'(err_out), 64'd0);
    masterOn = 1'b1;

    // Reset during WAIT_DONE
    dropDelay  = 2;
    xferLen    = 45;
    masterResp = 40'h0F_0F0F_0F0F;
    applyStimulus(12'h010);
    waitGrant(cyc);
    repeat (5) @(negedge clk_in);
    checkOutput("midEnLow", 64'(spi_send_enable_out), 64'd0);
    checkOutput("midGrantHeld", 64'(grant_out), 64'h010);
    #2 reset_n_in = 1'b0;
    #1;
    checkOutput("midRstGrant", 64'(grant_out), 64'd0);
    checkOutput("midRstBusy", 64'(busy_out), 64'd0);
    checkOutput("midRstData", 64'(spi_data_out), 64'd0);
    checkOutput("midRstCs", 64'(spi_cs_select_out), 64'd0);
    checkOutput("midRstResp", 64'(resp_data_out), 64'd0);
    repeat (50) @(negedge clk_in);
    applyStimulus(12'h801);
    reset_n_in = 1'b1;
    waitGrant(cyc);
    checkOutput("postRstFirst", 64'(grant_out), 64'h001);
    checkOutput("postRstData", 64'(spi_data_out), 64'(sliceData(0)));
    waitDone();
    applyStimulus(12'h800);
    waitGrant(cyc);
    checkOutput("postRstSecond", 64'(grant_out), 64'h800);
    waitDone();
    checkOutput("postRstResp", 64'(resp_data_out), 64'h0F_0F0F_0F0F);
    applyStimulus('0);

    // Request dropped mid-transfer still completes, no re-grant
    dropDelay  = 2;
    xferLen    = 6;
    masterResp = 40'h77_1234_0000;
    @(negedge clk_in);
    applyStimulus(12'h002);
    waitGrant(cyc);
    checkOutput("dropGrant", 64'(grant_out), 64'h002);
    repeat (4) @(negedge clk_in);
    applyStimulus('0);
    waitDone();
    checkOutput("dropDone", 64'(done_out), 64'h002);
    checkOutput("dropErr", 64'(err_out), 64'd0);
    checkOutput("dropResp", 64'(resp_data_out), 64'h77_1234_0000);
    sawGrant = 1'b0;
    repeat (6) begin
      @(negedge clk_in);
      if (grant_out != '0) sawGrant = 1'b1;
    end
    checkOutput("dropNoRegrant", 64'(sawGrant), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
